fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage of the 64-bit pipelined core. It owns the PC and drives a variable-latency instruction memory through a req/ack handshake. It buffers returned instructions in a 2-entry queue toward decode, with backpressure, and applies branch redirects, discarding any in-flight or stale fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_pkg;

  localparam int          FETCH_N        = 64;
  localparam int          FETCH_INSTR_W  = 32;
  localparam logic [63:0] PC_STEP_DEF    = 64'd4;
  localparam logic [63:0] RESET_PC_DEF   = 64'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_N-1:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The fetch credit rule must never let a push land on a full queue.
  no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    (push && !flush) |-> (count_q != 2'd2));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one imem request at a time,
// buffers returns for decode and applies branch redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          N        = FETCH_N,
  parameter int          INSTR_W  = FETCH_INSTR_W,
  parameter logic [N-1:0] PC_STEP  = PC_STEP_DEF[N-1:0],
  parameter logic [N-1:0] RESET_PC = RESET_PC_DEF[N-1:0]
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [N-1:0]       branch_target,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       instr_pc,
  input  logic               instr_ready,
  output fetch_state_t       dbg_state
);

  // Handshakes: an imem request is held with a stable address until a clock
  // edge samples imem_ack=1, which completes it. Decode takes the queue head
  // on any edge where instr_valid && instr_ready.

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] drop_addr_q, drop_addr_d;
  logic         push, pop, flush;
  logic [1:0]   count, next_count;
  fetch_entry_t head, push_entry;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready && !flush;
  assign next_count  = count + 2'd1 - {1'b0, pop};
  assign push_entry  = '{instr: imem_rdata, pc: pc_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    flush       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          flush   = 1'b1;
          pc_d    = branch_target;
          state_d = REQ;
        end else if (count < 2'd2) begin
          state_d = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          flush = 1'b1;
          pc_d  = branch_target;
          // Without an ack the old request is still in flight and must be drained.
          if (!imem_ack) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = (next_count < 2'd2) ? REQ : IDLE;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (branch_taken) begin
          flush = 1'b1;
          pc_d  = branch_target;
        end
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head       (head)
  );

  assign instr     = head.instr;
  assign instr_pc  = head.pc;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, backpressure, redirects, PC wrap.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         branch_taken;
  logic [63:0]  branch_target;
  logic         imem_req;
  logic [63:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [63:0]  instr_pc;
  logic         instr_ready;
  fetch_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns an address-tagged word so presented instructions are traceable.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'd0;
    imem_ack      = 1'b0;
    instr_ready   = 1'b0;

    // Reset values without any clock edge
    #2;
    check("rst_req", imem_req, 64'd0);
    check("rst_valid", instr_valid, 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_instr", instr, 64'd0);
    check("rst_pc", instr_pc, 64'd0);
    check("rst_state", dbg_state, IDLE);
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    #5 reset = 1'b1;
    #1;
    check("t1_idle_req", imem_req, 64'd0);

    // Zero-wait sequential fetch
    tick();
    check("t1_first_req", imem_req, 64'd1);
    check("t2_addr0", imem_addr, 64'h0);
    tick();
    check("t2_addr4", imem_addr, 64'h4);
    check("t2_valid0", instr_valid, 64'd1);
    check("t2_pc0", instr_pc, 64'h0);
    check("t2_instr0", instr, 64'hC0DE0000);
    tick();
    check("t2_addr8", imem_addr, 64'h8);
    check("t2_pc4", instr_pc, 64'h4);
    check("t2_instr4", instr, 64'hC0DE0004);
    tick();
    check("t2_addrc", imem_addr, 64'hC);
    check("t2_pc8", instr_pc, 64'h8);

    // Backpressure fills both entries, then drain in order
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    check("t3_addr0", imem_addr, 64'h0);
    tick();
    check("t3_addr4", imem_addr, 64'h4);
    tick();
    check("t3_full_req", imem_req, 64'd0);
    check("t3_full_state", dbg_state, IDLE);
    check("t3_head_pc", instr_pc, 64'h0);
    tick();
    check("t3_hold_req", imem_req, 64'd0);
    check("t3_hold_pc", instr_pc, 64'h0);
    check("t3_hold_instr", instr, 64'hC0DE0000);
    instr_ready = 1'b1;
    tick();
    check("t3_pop2_pc", instr_pc, 64'h4);
    check("t3_pop2_instr", instr, 64'hC0DE0004);
    check("t3_pop2_req", imem_req, 64'd0);
    tick();
    check("t3_resume_req", imem_req, 64'd1);
    check("t3_resume_addr", imem_addr, 64'h8);
    check("t3_empty", instr_valid, 64'd0);

    // Redirect during a slow request: old address held until drained
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h100;
    tick();
    branch_taken = 1'b0;
    check("t4_drop_state", dbg_state, DROP);
    check("t4_hold_addr_a", imem_addr, 64'h8);
    tick();
    check("t4_hold_addr_b", imem_addr, 64'h8);
    imem_ack = 1'b1;
    check("t4_hold_req", imem_req, 64'd1);
    tick();
    imem_ack = 1'b0;
    check("t4_new_addr", imem_addr, 64'h100);
    check("t4_no_stale", instr_valid, 64'd0);
    tick();
    check("t4_still_empty", instr_valid, 64'd0);
    check("t4_addr_stable", imem_addr, 64'h100);
    imem_ack = 1'b1;
    tick();
    check("t4_tgt_valid", instr_valid, 64'd1);
    check("t4_tgt_pc", instr_pc, 64'h100);
    check("t4_tgt_instr", instr, 64'hC0DE0100);
    check("t4_next_addr", imem_addr, 64'h104);

    // Redirect coinciding with ack and pop
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    tick();
    check("t5_one_entry", instr_pc, 64'h0);
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h200;
    tick();
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    check("t5_flushed", instr_valid, 64'd0);
    check("t5_addr", imem_addr, 64'h200);
    check("t5_req", imem_req, 64'd1);
    tick();
    check("t5_no_stale", instr_valid, 64'd0);

    // Redirect from IDLE with a full queue and a pop
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    do_reset();
    tick();
    tick();
    check("t5b_full_idle", dbg_state, IDLE);
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h300;
    tick();
    branch_taken = 1'b0;
    check("t5b_flushed", instr_valid, 64'd0);
    check("t5b_addr", imem_addr, 64'h300);
    check("t5b_state", dbg_state, REQ);

    // Redirect to the top of the address space; next fetch wraps to zero
    imem_ack      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("t6_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_discard", instr_valid, 64'd0);
    tick();
    check("t6_wrap_addr", imem_addr, 64'h0);
    check("t6_top_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_top_instr", instr, 64'hC0DEFFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
